// File: rtl/clken_gen_pkg.sv
// clken_gen_pkg: shared types and helpers for the fractional clock-enable
// generator.
//   state_e      : controller state (WAIT after reset, RUN, SETTLE after a
//                  ratio change)
//   lock_cnt_w   : width of the lock/settle counter for a given LOCK_CYCLES
//   cfg_is_valid : reconfiguration request check (channel in range,
//                  divisor nonzero, 0 < mul <= div)
package clken_gen_pkg;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } state_e;

    // The counter must be able to hold LOCK_CYCLES itself.
    function automatic int lock_cnt_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

    // Arguments are zero-extended to 32 bits by the caller, so the same
    // check serves every channel count and accumulator width up to 32.
    function automatic logic cfg_is_valid(input logic [31:0] ch,
                                          input logic [31:0] num_ch,
                                          input logic [31:0] mul,
                                          input logic [31:0] div);
        return (ch < num_ch) && (div != 32'd0) && (mul != 32'd0) && (mul <= div);
    endfunction

endpackage

// File: rtl/clken_gen_if.sv
// clken_gen_if: configuration handshake and enable outputs of clken_gen.
//   cfg_valid/cfg_ready : request handshake
//   cfg_ch/mul/div      : request payload
//   cfg_err             : one-cycle pulse, previous accepted request rejected
//   ce                  : per-channel enable pulses
//   locked              : high while all channels run at their programmed ratio
//
// Handshake: a request is accepted on a rising edge where cfg_valid and
// cfg_ready are both high. The master holds cfg_ch/mul/div stable while
// cfg_valid is high and must not withdraw an unaccepted request. cfg_ready
// is high only in RUN, so a request raised during WAIT/SETTLE simply waits.
interface clken_gen_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_mul;
    logic [ACC_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] ce;
    logic              locked;

    modport master (
        output cfg_valid, cfg_ch, cfg_mul, cfg_div,
        input  cfg_ready, cfg_err, ce, locked
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mul, cfg_div,
        output cfg_ready, cfg_err, ce, locked
    );
endinterface

// File: rtl/clken_gen_ch.sv
// clken_gen_ch: one fractional enable channel.
//   refclk, rst_n : clock, async active-low reset
//   load_i        : take mul_i/div_i as the new ratio and clear the accumulator
//   hold_i        : keep the accumulator at 0 and the enable low
//   mul_i, div_i  : new ratio, used only with load_i
//   ce_o          : registered enable pulse
// Each running cycle adds mul to the accumulator; when the sum reaches div,
// div is subtracted and a pulse is produced.
module clken_gen_ch #(
    parameter int               ACC_W    = 16,
    parameter logic [ACC_W-1:0] INIT_MUL = 1,
    parameter logic [ACC_W-1:0] INIT_DIV = 1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             hold_i,
    input  logic [ACC_W-1:0] mul_i,
    input  logic [ACC_W-1:0] div_i,
    output logic             ce_o
);
    logic [ACC_W-1:0] mul_q, mul_d;
    logic [ACC_W-1:0] div_q, div_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ce_q, ce_d;
    // One extra bit so mul = div = 2^ACC_W-1 cannot wrap.
    logic [ACC_W:0]   sum;

    always_comb begin
        mul_d = mul_q;
        div_d = div_q;
        acc_d = acc_q;
        ce_d  = 1'b0;
        sum   = {1'b0, acc_q} + {1'b0, mul_q};
        if (load_i) begin
            mul_d = mul_i;
            div_d = div_i;
            acc_d = '0;
        end else if (hold_i) begin
            acc_d = '0;
        end else if (sum >= {1'b0, div_q}) begin
            // acc < div and mul <= div, so the difference is below div.
            acc_d = ACC_W'(sum - {1'b0, div_q});
            ce_d  = 1'b1;
        end else begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            mul_q <= INIT_MUL;
            div_q <= INIT_DIV;
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            mul_q <= mul_d;
            div_q <= div_d;
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;
endmodule

// File: rtl/clken_gen.sv
// clken_gen: NUM_CH fractional clock-enable streams at f_ref*MUL/DIV with
// runtime reprogramming and a lock indicator.
//   refclk, rst_n : reference clock, async active-low reset
//   bus           : clken_gen_if slave (config handshake, ce, locked)
//   state_o       : current controller state, for observation
// The controller waits LOCK_CYCLES after reset, then runs. A valid request
// loads the target channel and holds it for LOCK_CYCLES (SETTLE) while the
// other channels keep running; an invalid request only pulses cfg_err.
module clken_gen
    import clken_gen_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 16,
    parameter int                      LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_MUL    = {16'd1, 16'd1},
    parameter logic [NUM_CH*ACC_W-1:0] INIT_DIV    = {16'd5, 16'd1}
) (
    input  logic        refclk,
    input  logic        rst_n,
    clken_gen_if.slave  bus,
    output state_e      state_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LCW  = lock_cnt_w(LOCK_CYCLES);

    state_e          state_q, state_d;
    logic [LCW-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0] settle_ch_q, settle_ch_d;
    logic            locked_q, ready_q, err_q, err_d;
    logic            accept, req_ok, cfg_write;
    logic [NUM_CH-1:0] load_w, hold_w, ce_w;

    assign accept    = bus.cfg_valid && ready_q;
    assign req_ok    = cfg_is_valid(32'(bus.cfg_ch), 32'(NUM_CH),
                                    32'(bus.cfg_mul), 32'(bus.cfg_div));
    assign cfg_write = accept && req_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settle_ch_d = settle_ch_q;
        err_d       = 1'b0;
        case (state_q)
            WAIT, SETTLE: begin
                if (cnt_q == LCW'(LOCK_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LCW'(1);
                end
            end
            RUN: begin
                if (cfg_write) begin
                    state_d     = SETTLE;
                    cnt_d       = '0;
                    settle_ch_d = bus.cfg_ch;
                end else if (accept) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT;
            cnt_q       <= '0;
            settle_ch_q <= '0;
            locked_q    <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_ch_q <= settle_ch_d;
            locked_q    <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
            err_q       <= err_d;
        end
    end

    // Channel controls are decoded from the next state so that the cycle
    // in which locked first reads high is already counting step k=1.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign load_w[g] = cfg_write && (bus.cfg_ch == CH_W'(g));
        assign hold_w[g] = (state_d == WAIT) ||
                           ((state_d == SETTLE) && (settle_ch_d == CH_W'(g)));

        clken_gen_ch #(
            .ACC_W    (ACC_W),
            .INIT_MUL (INIT_MUL[g*ACC_W +: ACC_W]),
            .INIT_DIV (INIT_DIV[g*ACC_W +: ACC_W])
        ) u_ch (
            .refclk (refclk),
            .rst_n  (rst_n),
            .load_i (load_w[g]),
            .hold_i (hold_w[g]),
            .mul_i  (bus.cfg_mul),
            .div_i  (bus.cfg_div),
            .ce_o   (ce_w[g])
        );
    end

    assign bus.ce        = ce_w;
    assign bus.locked    = locked_q;
    assign bus.cfg_ready = ready_q;
    assign bus.cfg_err   = err_q;
    assign state_o       = state_q;
endmodule
